omsp_trig_gpio: RTL

OMSP_TRIG_GPIO -- requirements
Module: omsp_trig_gpio

---
 rtl/omsp_trig_gpio.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/omsp_trig_gpio.sv
// GPIO port with edge-flag interrupts and a delayed scope-trigger pulse.
// Sits on the openMSP430-style peripheral bus (word address, byte enables).
module omsp_trig_gpio #(
    parameter int          NCH         = 16,
    parameter logic [14:0] BASE_ADDR   = 15'h0090,
    parameter int          SYNC_STAGES = 2
) (
    input  logic            mclk,
    input  logic            puc_rst,
    input  logic [13:0]     per_addr,
    input  logic [15:0]     per_din,
    input  logic            per_en,
    input  logic [1:0]      per_we,
    output logic [15:0]     per_dout,
    input  logic [NCH-1:0]  gpio_in,
    output logic [NCH-1:0]  gpio_out,
    output logic [NCH-1:0]  gpio_oe,
    output logic            trig_out,
    output logic            irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } state_t;

    localparam logic [10:0] BASE_HI = BASE_ADDR[14:4];

    localparam logic [2:0] R_DIN  = 3'd0;
    localparam logic [2:0] R_DOUT = 3'd1;
    localparam logic [2:0] R_DIR  = 3'd2;
    localparam logic [2:0] R_IFG  = 3'd3;
    localparam logic [2:0] R_IE   = 3'd4;
    localparam logic [2:0] R_IES  = 3'd5;
    localparam logic [2:0] R_CFG  = 3'd6;
    localparam logic [2:0] R_CTL  = 3'd7;

    // Byte-lane merge of a write into an NCH-wide register.
    function automatic logic [NCH-1:0] merge_n(
        input logic [NCH-1:0] old_v,
        input logic [15:0]    new_v,
        input logic [15:0]    m
    );
        merge_n = (old_v & ~m[NCH-1:0]) | (new_v[NCH-1:0] & m[NCH-1:0]);
    endfunction

    // Zero-extend an NCH-wide register to the bus width.
    function automatic logic [15:0] ext(input logic [NCH-1:0] v);
        ext          = '0;
        ext[NCH-1:0] = v;
    endfunction

    logic        sel;
    logic        wr;
    logic        rd;
    logic [2:0]  off;
    logic [15:0] wmask;
    logic        start;
    logic        abort;

    assign sel   = per_en && (per_addr[13:3] == BASE_HI);
    assign off   = per_addr[2:0];
    assign wr    = sel && (per_we != 2'b00);
    assign rd    = sel && (per_we == 2'b00);
    assign wmask = {{8{per_we[1]}}, {8{per_we[0]}}};
    assign start = wr && (off == R_CTL) && per_we[0] && per_din[0];
    assign abort = wr && (off == R_CTL) && per_we[0] && per_din[2];

    logic [SYNC_STAGES-1:0][NCH-1:0] sync_q, sync_d;
    logic [NCH-1:0] prev_q, prev_d;
    logic [NCH-1:0] dout_q, dout_d;
    logic [NCH-1:0] dir_q, dir_d;
    logic [NCH-1:0] ifg_q, ifg_d;
    logic [NCH-1:0] ie_q, ie_d;
    logic [NCH-1:0] ies_q, ies_d;
    logic [15:0]    cfg_q, cfg_d;
    logic           irq_q, irq_d;
    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [7:0]     wid_q, wid_d;
    logic           trig_q, trig_d;

    logic [NCH-1:0] din;
    logic [NCH-1:0] det;

    assign din = sync_q[SYNC_STAGES-1];

    // Synchroniser shift, edge detect and software-visible registers.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], gpio_in};
        prev_d = din;
        det    = (din & ~prev_q & ~ies_q) | (~din & prev_q & ies_q);
        dout_d = dout_q;
        dir_d  = dir_q;
        ie_d   = ie_q;
        ies_d  = ies_q;
        cfg_d  = cfg_q;
        ifg_d  = ifg_q;
        if (wr) begin
            unique case (off)
                R_DOUT:  dout_d = merge_n(dout_q, per_din, wmask);
                R_DIR:   dir_d  = merge_n(dir_q, per_din, wmask);
                R_IE:    ie_d   = merge_n(ie_q, per_din, wmask);
                R_IES:   ies_d  = merge_n(ies_q, per_din, wmask);
                R_CFG:   cfg_d  = (cfg_q & ~wmask) | (per_din & wmask);
                R_IFG:   ifg_d  = ifg_q & ~(per_din[NCH-1:0] & wmask[NCH-1:0]);
                default: ;
            endcase
        end
        // A fresh edge beats a simultaneous write-1-clear.
        ifg_d = ifg_d | det;
        irq_d = |(ifg_q & ie_q);
    end

    // Trigger sequencer: optional delay, then a pulse of at least one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wid_d   = wid_q;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        wid_d = (cfg_q[7:0] == 8'd0) ? 8'd1 : cfg_q[7:0];
                        if (cfg_q[15:8] != 8'd0) begin
                            state_d = DELAY;
                            cnt_d   = cfg_q[15:8];
                        end else begin
                            state_d = PULSE;
                            cnt_d   = (cfg_q[7:0] == 8'd0) ? 8'd1 : cfg_q[7:0];
                        end
                    end
                end
                DELAY: begin
                    if (cnt_q <= 8'd1) begin
                        state_d = PULSE;
                        cnt_d   = wid_q;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                PULSE: begin
                    if (cnt_q <= 8'd1) begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
        trig_d = (state_d == PULSE);
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            sync_q  <= '0;
            prev_q  <= '0;
            dout_q  <= '0;
            dir_q   <= '0;
            ifg_q   <= '0;
            ie_q    <= '0;
            ies_q   <= '0;
            cfg_q   <= '0;
            irq_q   <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            wid_q   <= '0;
            trig_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            dout_q  <= dout_d;
            dir_q   <= dir_d;
            ifg_q   <= ifg_d;
            ie_q    <= ie_d;
            ies_q   <= ies_d;
            cfg_q   <= cfg_d;
            irq_q   <= irq_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wid_q   <= wid_d;
            trig_q  <= trig_d;
        end
    end

    // Read mux; zero whenever the cycle is not a read of this block.
    always_comb begin
        per_dout = 16'h0000;
        if (rd) begin
            unique case (off)
                R_DIN:   per_dout = ext(din);
                R_DOUT:  per_dout = ext(dout_q);
                R_DIR:   per_dout = ext(dir_q);
                R_IFG:   per_dout = ext(ifg_q);
                R_IE:    per_dout = ext(ie_q);
                R_IES:   per_dout = ext(ies_q);
                R_CFG:   per_dout = cfg_q;
                R_CTL:   per_dout = {14'd0, (state_q != IDLE), 1'b0};
                default: per_dout = 16'h0000;
            endcase
        end
    end

    assign gpio_out = dout_q;
    assign gpio_oe  = dir_q;
    assign trig_out = trig_q;
    assign irq      = irq_q;

endmodule
